// File: rtl/clock12_ctrl.sv
// 12-hour time-of-day clock controller.
// Divides clk down to a 1 s tick and runs a seconds -> minutes -> hours (mod 12)
// carry chain with an AM/PM flag. A three-state mode FSM (RUN, SET_HR, SET_MIN)
// lets the user set hours and minutes from pre-debounced single-cycle button
// pulses. Every output is a register.
module clock12_ctrl #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       pm,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic          pm_q, pm_d;
    logic          tick_q, tick_d;

    // State register: synchronous reset has priority over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            presc_q   <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            pm_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            pm_q      <= pm_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state logic: mode FSM, prescaler, carry chain and field setting.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        pm_d      = pm_q;
        tick_d    = 1'b0;

        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    // Time is frozen from this edge on; fields are kept as-is.
                    state_d = SET_HR;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    // Whole carry chain resolves on this single edge.
                    if (seconds_q == 6'd59) begin
                        seconds_d = '0;
                        if (minutes_q == 6'd59) begin
                            minutes_d = '0;
                            if (hours_q == 4'd11) begin
                                hours_d = '0;
                                pm_d    = ~pm_q;
                            end else begin
                                hours_d = hours_q + 4'd1;
                            end
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            SET_HR: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    if (hours_q == 4'd11) begin
                        hours_d = '0;
                        pm_d    = ~pm_q;
                    end else begin
                        hours_d = hours_q + 4'd1;
                    end
                end
            end

            SET_MIN: begin
                presc_d = '0;
                if (btn_mode) begin
                    // Restart the second from zero so the first tick is a full period away.
                    state_d   = RUN;
                    seconds_d = '0;
                end else if (btn_inc) begin
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                end
            end

            default: begin
                state_d = RUN;
                presc_d = '0;
            end
        endcase
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign pm       = pm_q;
    assign mode     = state_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock12_ctrl.sv
// Testbench for clock12_ctrl with CLK_HZ=4. Directed scenarios plus a randomized
// run against a reference model that keeps time as seconds-since-midnight.
module tb_clock12_ctrl;

    localparam int K = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic [1:0] mode;
    logic       sec_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time of day in seconds (0..86399), mode number,
    // edge counter and the edge index at which RUN was (re)started.
    int m_t     = 0;
    int m_mode  = 0;
    int m_tick  = 0;
    int cyc     = 0;
    int run_start = 0;

    clock12_ctrl #(.CLK_HZ(K)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .pm       (pm),
        .mode     (mode),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic int exp_h();  return (m_t / 3600) % 12; endfunction
    function automatic int exp_m();  return (m_t / 60) % 60;   endfunction
    function automatic int exp_s();  return m_t % 60;          endfunction
    function automatic int exp_pm(); return m_t / 43200;       endfunction

    task automatic model_step(input logic r, input logic bm, input logic bi);
        int mm;
        m_tick = 0;
        if (r) begin
            m_t = 0; m_mode = 0; run_start = cyc;
        end else begin
            case (m_mode)
                0: begin
                    if (bm) m_mode = 1;
                    else if (((cyc - run_start) % K) == 0) begin
                        m_t = (m_t + 1) % 86400;
                        m_tick = 1;
                    end
                end
                1: begin
                    if (bm) m_mode = 2;
                    else if (bi) m_t = (m_t + 3600) % 86400;
                end
                default: begin
                    if (bm) begin
                        m_mode = 0;
                        m_t = m_t - (m_t % 60);
                        run_start = cyc;
                    end else if (bi) begin
                        mm = (m_t / 60) % 60;
                        m_t = m_t + (((mm + 1) % 60) - mm) * 60;
                    end
                end
            endcase
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic bm, input logic bi);
        reset = r; btn_mode = bm; btn_inc = bi;
        @(posedge clk);
        cyc++;
        model_step(r, bm, bi);
        #1;
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({hours, minutes, seconds, pm, mode, sec_tick} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_state: h=%0d m=%0d s=%0d pm=%0d mode=%0d tick=%0d, expected all 0",
                     hours, minutes, seconds, pm, mode, sec_tick);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (sec_tick !== 1'b0 || seconds !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_early_tick: cycle %0d tick=%0d s=%0d, expected tick=0 s=0", i, sec_tick, seconds);
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sec_tick !== 1'b1 || seconds !== 6'd1) begin
            n_fail++;
            $display("FAIL reset_first_tick: tick=%0d s=%0d, expected tick=1 s=1", sec_tick, seconds);
        end
    endtask

    task automatic test_set_hours_wrap();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (hours !== 4'd11 || pm !== 1'b0 || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL set_hr_11: h=%0d pm=%0d mode=%0d, expected h=11 pm=0 mode=1", hours, pm, mode);
        end
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (hours !== 4'd0 || pm !== 1'b1 || minutes !== 6'd0) begin
            n_fail++;
            $display("FAIL set_hr_wrap: h=%0d pm=%0d m=%0d, expected h=0 pm=1 m=0", hours, pm, minutes);
        end
    endtask

    task automatic test_noon_rollover();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'd0 || hours !== 4'd11 || minutes !== 6'd59 || seconds !== 6'd0 || pm !== 1'b0) begin
            n_fail++;
            $display("FAIL noon_setup: mode=%0d %0d:%0d:%0d pm=%0d, expected mode=0 11:59:0 pm=0",
                     mode, hours, minutes, seconds, pm);
        end
        for (int i = 0; i < 239; i++) cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (hours !== 4'd11 || minutes !== 6'd59 || seconds !== 6'd59 || pm !== 1'b0) begin
            n_fail++;
            $display("FAIL noon_before: %0d:%0d:%0d pm=%0d, expected 11:59:59 pm=0", hours, minutes, seconds, pm);
        end
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (hours !== 4'd0 || minutes !== 6'd0 || seconds !== 6'd0 || pm !== 1'b1 || sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL noon_rollover: %0d:%0d:%0d pm=%0d tick=%0d, expected 0:0:0 pm=1 tick=1",
                     hours, minutes, seconds, pm, sec_tick);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mode !== 2'd2 || hours !== 4'd3 || minutes !== 6'd0) begin
            n_fail++;
            $display("FAIL simultaneous: mode=%0d h=%0d m=%0d, expected mode=2 h=3 m=0", mode, hours, minutes);
        end
    endtask

    task automatic test_freeze();
        logic bad;
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (seconds !== 6'd2 || sec_tick !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL freeze: s=%0d tick=%0d at end, expected s=2 tick=0 throughout", seconds, sec_tick);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'd0 || seconds !== 6'd0) begin
            n_fail++;
            $display("FAIL freeze_exit: mode=%0d s=%0d, expected mode=0 s=0", mode, seconds);
        end
    endtask

    task automatic test_reset_mid_set();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 42; i++) cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (mode !== 2'd2 || minutes !== 6'd42) begin
            n_fail++;
            $display("FAIL mid_set_setup: mode=%0d m=%0d, expected mode=2 m=42", mode, minutes);
        end
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({hours, minutes, seconds, pm, mode, sec_tick} !== 20'd0) begin
            n_fail++;
            $display("FAIL mid_set_reset: h=%0d m=%0d s=%0d pm=%0d mode=%0d, expected all 0",
                     hours, minutes, seconds, pm, mode);
        end
    endtask

    task automatic test_random();
        logic r, bm, bi;
        logic [19:0] exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            bm = ($urandom_range(0, 29) == 0);
            bi = ($urandom_range(0, 2) == 0);
            cycle(r, bm, bi);
            exp_v = {4'(exp_h()), 6'(exp_m()), 6'(exp_s()), 1'(exp_pm()), 2'(m_mode), 1'(m_tick)};
            n_checks++;
            if ({hours, minutes, seconds, pm, mode, sec_tick} !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %0d:%0d:%0d pm=%0d mode=%0d tick=%0d, expected %0d:%0d:%0d pm=%0d mode=%0d tick=%0d",
                         i, hours, minutes, seconds, pm, mode, sec_tick,
                         exp_h(), exp_m(), exp_s(), exp_pm(), m_mode, m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_hours_wrap();
        test_noon_rollover();
        test_simultaneous();
        test_freeze();
        test_reset_mid_set();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
